// File: rtl/trig_taylor_seq.sv
// Multi-cycle sine/cosine from an integer angle in degrees, using a truncated
// Taylor series on one shared signed multiplier. Cosine is sin(angle + 90).
`timescale 1ns/1ps
module trig_taylor_seq #(
  parameter int unsigned ANGLE_W = 11,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned WIDTH   = 20,
  parameter int unsigned TERMS   = 5
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ANGLE_W-1:0]      angle,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result
);

  localparam int unsigned AW = ANGLE_W + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned KW = 3;

  // round(2^FRAC / ((2k)(2k+1))), evaluated at elaboration only
  function automatic longint unsigned rcp_calc(input int unsigned k);
    longint unsigned d;
    d = 64'((2 * k) * (2 * k + 1));
    return ((64'd1 << FRAC) + (d >> 1)) / d;
  endfunction

  // round(pi/180 * 2^FRAC) using pi scaled by 1e12 in 64-bit integers
  localparam longint unsigned PI_E12  = 64'd3141592653590;
  localparam longint unsigned DEG_E12 = 64'd180000000000000;
  localparam logic [WIDTH-1:0] K_RAD  =
    WIDTH'(((PI_E12 << FRAC) + (DEG_E12 >> 1)) / DEG_E12);

  localparam logic signed [WIDTH-1:0] RCP1 = WIDTH'(rcp_calc(1));
  localparam logic signed [WIDTH-1:0] RCP2 = WIDTH'(rcp_calc(2));
  localparam logic signed [WIDTH-1:0] RCP3 = WIDTH'(rcp_calc(3));
  localparam logic signed [WIDTH-1:0] RCP4 = WIDTH'(rcp_calc(4));
  localparam logic signed [WIDTH-1:0] RCP5 = WIDTH'(rcp_calc(5));
  localparam logic signed [WIDTH-1:0] RCP6 = WIDTH'(rcp_calc(6));

  typedef enum logic [2:0] {
    IDLE, REDUCE, QUAD, TORAD, SQUARE, MULX2, MULRCP, HOLD
  } state_t;

  state_t                  r_state;
  logic [AW-1:0]           r_a;
  logic [AW-1:0]           r_r;
  logic                    r_neg;
  logic signed [WIDTH-1:0] r_x;
  logic signed [WIDTH-1:0] r_x2;
  logic signed [WIDTH-1:0] r_term;
  logic signed [WIDTH-1:0] r_p;
  logic signed [WIDTH-1:0] r_acc;
  logic [KW-1:0]           r_k;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [WIDTH-1:0] r_result;

  state_t                  w_state_nxt;
  logic [AW-1:0]           w_a_nxt;
  logic [AW-1:0]           w_r_nxt;
  logic                    w_neg_nxt;
  logic signed [WIDTH-1:0] w_x_nxt;
  logic signed [WIDTH-1:0] w_x2_nxt;
  logic signed [WIDTH-1:0] w_term_nxt;
  logic signed [WIDTH-1:0] w_p_nxt;
  logic signed [WIDTH-1:0] w_acc_nxt;
  logic [KW-1:0]           w_k_nxt;
  logic signed [WIDTH-1:0] w_result_nxt;
  logic                    w_in_ready_nxt;
  logic                    w_out_valid_nxt;

  logic signed [WIDTH-1:0] w_rcp;
  logic signed [WIDTH-1:0] w_mul_a;
  logic signed [WIDTH-1:0] w_mul_b;
  logic signed [PW-1:0]    w_prod;
  logic signed [WIDTH-1:0] w_prod_q;
  logic signed [WIDTH-1:0] w_acc_new;

  // Reciprocal factorial-ratio table indexed by term number
  always_comb begin
    w_rcp = RCP1;
    case (r_k)
      3'd2:    w_rcp = RCP2;
      3'd3:    w_rcp = RCP3;
      3'd4:    w_rcp = RCP4;
      3'd5:    w_rcp = RCP5;
      3'd6:    w_rcp = RCP6;
      default: w_rcp = RCP1;
    endcase
  end

  // Shared multiplier: x*x in SQUARE, term*x2 in MULX2, p*RCP in MULRCP
  always_comb begin
    w_mul_a = r_x;
    w_mul_b = r_x;
    case (r_state)
      MULX2: begin
        w_mul_a = r_term;
        w_mul_b = r_x2;
      end
      MULRCP: begin
        w_mul_a = r_p;
        w_mul_b = w_rcp;
      end
      default: ;
    endcase
  end

  assign w_prod    = PW'(w_mul_a) * PW'(w_mul_b);
  assign w_prod_q  = WIDTH'(w_prod >>> FRAC);
  // New term is the negated scaled product, so it is subtracted here
  assign w_acc_new = r_acc - w_prod_q;

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_r_nxt      = r_r;
    w_neg_nxt    = r_neg;
    w_x_nxt      = r_x;
    w_x2_nxt     = r_x2;
    w_term_nxt   = r_term;
    w_p_nxt      = r_p;
    w_acc_nxt    = r_acc;
    w_k_nxt      = r_k;
    w_result_nxt = r_result;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_a_nxt     = AW'(angle) + (mode ? AW'(90) : AW'(0));
          w_state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        if (r_a >= AW'(360)) begin
          w_a_nxt = r_a - AW'(360);
        end else begin
          w_state_nxt = QUAD;
        end
      end
      QUAD: begin
        w_state_nxt = TORAD;
        if (r_a <= AW'(90)) begin
          w_r_nxt   = r_a;
          w_neg_nxt = 1'b0;
        end else if (r_a <= AW'(180)) begin
          w_r_nxt   = AW'(180) - r_a;
          w_neg_nxt = 1'b0;
        end else if (r_a <= AW'(270)) begin
          w_r_nxt   = r_a - AW'(180);
          w_neg_nxt = 1'b1;
        end else begin
          w_r_nxt   = AW'(360) - r_a;
          w_neg_nxt = 1'b1;
        end
      end
      TORAD: begin
        w_x_nxt     = WIDTH'(r_r) * K_RAD;
        w_term_nxt  = WIDTH'(r_r) * K_RAD;
        w_acc_nxt   = WIDTH'(r_r) * K_RAD;
        w_k_nxt     = KW'(1);
        w_state_nxt = SQUARE;
      end
      SQUARE: begin
        w_x2_nxt = w_prod_q;
        if (TERMS == 1) begin
          w_result_nxt = r_neg ? -r_acc : r_acc;
          w_state_nxt  = HOLD;
        end else begin
          w_state_nxt  = MULX2;
        end
      end
      MULX2: begin
        w_p_nxt     = w_prod_q;
        w_state_nxt = MULRCP;
      end
      MULRCP: begin
        w_term_nxt = -w_prod_q;
        w_acc_nxt  = w_acc_new;
        w_k_nxt    = r_k + KW'(1);
        if (r_k == KW'(TERMS - 1)) begin
          w_result_nxt = r_neg ? -w_acc_new : w_acc_new;
          w_state_nxt  = HOLD;
        end else begin
          w_state_nxt  = MULX2;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // in_ready stays low on the first IDLE cycle after a result is taken
  assign w_in_ready_nxt  = (r_state == IDLE) && (w_state_nxt == IDLE);
  assign w_out_valid_nxt = (w_state_nxt == HOLD);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_r         <= '0;
      r_neg       <= 1'b0;
      r_x         <= '0;
      r_x2        <= '0;
      r_term      <= '0;
      r_p         <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_r         <= w_r_nxt;
      r_neg       <= w_neg_nxt;
      r_x         <= w_x_nxt;
      r_x2        <= w_x2_nxt;
      r_term      <= w_term_nxt;
      r_p         <= w_p_nxt;
      r_acc       <= w_acc_nxt;
      r_k         <= w_k_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_result    <= w_result_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_trig_taylor_seq.sv
// Scoreboard bench for trig_taylor_seq: requests push expected results and
// latencies; a monitor pops and compares whenever out_valid rises.
`timescale 1ns/1ps
module tb_trig_taylor_seq;

  localparam int unsigned ANGLE_W = 11;
  localparam int unsigned FRAC    = 16;
  localparam int unsigned WIDTH   = 20;
  localparam int unsigned TERMS   = 5;
  localparam int          TOL     = 4;
  localparam real         PI      = 3.14159265358979323846;

  typedef struct {
    int     ang;
    bit     md;
    int     want;
    bit     exact;
    int     lat;
    longint acc_cyc;
  } exp_t;

  logic                    clock     = 1'b0;
  logic                    resetn    = 1'b0;
  logic                    in_valid  = 1'b0;
  logic                    in_ready;
  logic [ANGLE_W-1:0]      angle     = '0;
  logic                    mode      = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [WIDTH-1:0] result;

  exp_t   sb[$];
  int     n_chk     = 0;
  int     n_err     = 0;
  longint cyc       = 0;
  bit     busy      = 1'b0;
  bit     prev_ov   = 1'b0;
  bit     fall_pend = 1'b0;
  int     or_mode   = 0;
  logic signed [WIDTH-1:0] held;

  trig_taylor_seq #(
    .ANGLE_W(ANGLE_W), .FRAC(FRAC), .WIDTH(WIDTH), .TERMS(TERMS)
  ) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .angle(angle), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want, input int tol);
    int d;
    d = got - want;
    if (d < 0) d = -d;
    n_chk++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d) at %0t", name, got, want, tol, $time);
    end
  endtask

  // The radian angle is quantised by round(pi/180*2^FRAC) per degree, which alone
  // shifts mid-range results ~6 LSB; the reference is the sine of that value.
  function automatic void model(input int ang, input bit md,
                                output int want, output bit exact, output int lat);
    int  full, deg, t, r;
    bit  neg;
    real scale, k_rad, s;
    full  = ang + (md ? 90 : 0);
    deg   = full % 360;
    t     = (deg % 180) - 90;
    if (t < 0) t = -t;
    r     = 90 - t;
    neg   = (deg > 180);
    scale = 2.0 ** FRAC;
    k_rad = $floor(PI / 180.0 * scale + 0.5);
    s     = $sin(real'(r) * k_rad / scale) * scale;
    want  = $rtoi($floor(s + 0.5));
    if (neg) want = -want;
    exact = (r == 0);
    lat   = 4 + full / 360 + 2 * (int'(TERMS) - 1);
  endfunction

  task automatic issue(input int ang, input bit md);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clock);
    while (!in_ready && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL issue_timeout: in_ready stuck at %0d for angle %0d", in_ready, ang);
      return;
    end
    in_valid = 1'b1;
    angle    = ANGLE_W'(ang);
    mode     = md;
    @(negedge clock);
    in_valid = 1'b0;
    angle    = ANGLE_W'($urandom);
    mode     = 1'($urandom);
    model(ang, md, e.want, e.exact, e.lat);
    e.ang     = ang;
    e.md      = md;
    e.acc_cyc = cyc;
    sb.push_back(e);
    busy = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while ((busy || sb.size() != 0) && w < budget) begin
      @(negedge clock);
      w++;
    end
    if (busy || sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
    end
    @(negedge clock);
  endtask

  // out_ready driver: 0 = always ready, 1 = random backpressure, 2 = held low
  initial begin
    forever begin
      @(negedge clock);
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (($urandom % 4) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: result/latency on rise, stability while held, in_ready around the drop
  always @(negedge clock) begin
    exp_t cur;
    if (!resetn) begin
      prev_ov   = 1'b0;
      fall_pend = 1'b0;
    end else begin
      if (fall_pend) begin
        check("in_ready_after_drop", int'(in_ready), 1, 0);
        fall_pend = 1'b0;
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_out_valid: result %0d with no request pending", result);
        end else begin
          cur = sb.pop_front();
          check($sformatf("latency(ang=%0d,mode=%0d)", cur.ang, cur.md),
                int'(cyc - cur.acc_cyc), cur.lat, 0);
          check($sformatf("result(ang=%0d,mode=%0d)", cur.ang, cur.md),
                int'(result), cur.want, cur.exact ? 0 : TOL);
          check("in_ready_in_hold", int'(in_ready), 0, 0);
        end
        held = result;
      end else if (out_valid && prev_ov) begin
        check("hold_stable", int'(result), int'(held), 0);
      end
      if (!out_valid && prev_ov) begin
        busy = 1'b0;
        check("in_ready_at_drop", int'(in_ready), 0, 0);
        fall_pend = 1'b1;
      end
      if (busy && !out_valid) check("in_ready_busy", int'(in_ready), 0, 0);
      prev_ov = out_valid;
    end
  end

  int d_ang [17] = '{30, 90, 0, 180, 210, 0, 120, 90, 390, 2040,
                     359, 360, 270, 271, 2047, 2047, 1};
  bit d_md  [17] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0,
                     0, 0, 0, 1, 0, 1, 1};

  initial begin
    int w;
    repeat (3) @(negedge clock);
    check("reset_in_ready", int'(in_ready), 1, 0);
    check("reset_out_valid", int'(out_valid), 0, 0);
    check("reset_result", int'(result), 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < 17; i++) issue(d_ang[i], d_md[i]);
    wait_idle(200);

    // Backpressure: result must stay put and new requests must be ignored
    or_mode = 2;
    @(negedge clock);
    issue(45, 1'b0);
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clock);
      w++;
    end
    check("hold_reached", int'(out_valid), 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      in_valid = (i % 4 == 1);
      angle    = ANGLE_W'($urandom);
    end
    in_valid = 1'b0;
    check("hold_out_valid", int'(out_valid), 1, 0);
    @(negedge clock);
    or_mode   = 0;
    out_ready = 1'b1;
    @(negedge clock);
    check("hold_release", int'(out_valid), 0, 0);
    wait_idle(50);

    // Reset while the series is being evaluated
    issue(75, 1'b0);
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midreset_out_valid", int'(out_valid), 0, 0);
    check("midreset_result", int'(result), 0, 0);
    check("midreset_in_ready", int'(in_ready), 1, 0);
    sb.delete();
    busy = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    issue(60, 1'b1);
    wait_idle(50);

    or_mode = 1;
    for (int i = 0; i < 120; i++) begin
      issue(int'($urandom_range(0, 2047)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d results outstanding", sb.size());
    $fatal(1, "watchdog expired");
  end

endmodule
